// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and the read-engine state type.
//  AXI_BURST_INCR : ARBURST encoding for incrementing bursts
//  AXI_RESP_OKAY  : RRESP encoding for a good beat
//  AXI_4KB        : size of the address window no burst may cross
//  state_e        : read-engine FSM states
package axi4_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         AXI_4KB        = 4096;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/axi4_burst_splitter.sv
// Combinational burst sizing for the read engine.
// Ports:
//  rem_beats_i : beats still to be requested for the transfer
//  addr_lo_i   : low 12 bits of the next burst address
//  beats_o     : min(rem_beats, MAX_BURST_LEN, beats left before the next 4 KB boundary)
//  arlen_o     : beats_o - 1, in ARLEN encoding
module axi4_burst_splitter
   import axi4_pkg::*;
#(
   parameter int TRAN_BYTE_NUM_WIDTH = 16,
   parameter int DATA_BYTES          = 4,
   parameter int MAX_BURST_LEN       = 16
) (
   input  logic [TRAN_BYTE_NUM_WIDTH-1:0] rem_beats_i,
   input  logic [11:0]                    addr_lo_i,
   output logic [TRAN_BYTE_NUM_WIDTH-1:0] beats_o,
   output logic [7:0]                     arlen_o
);

   localparam int SIZE = $clog2(DATA_BYTES);
   // Compare in a width that holds both the beat count and a full 4 KB page of beats.
   localparam int CW   = (TRAN_BYTE_NUM_WIDTH > 13) ? TRAN_BYTE_NUM_WIDTH : 13;

   logic [12:0]   page_bytes;
   logic [CW-1:0] rem_c;
   logic [CW-1:0] page_c;
   logic [CW-1:0] mbl_c;
   logic [CW-1:0] min_c;

   assign page_bytes = 13'(AXI_4KB) - {1'b0, addr_lo_i};
   assign rem_c      = CW'(rem_beats_i);
   assign page_c     = CW'(page_bytes >> SIZE);
   assign mbl_c      = CW'(MAX_BURST_LEN);

   always_comb begin
      min_c = rem_c;
      if (mbl_c < min_c) begin
         min_c = mbl_c;
      end
      if (page_c < min_c) begin
         min_c = page_c;
      end
   end

   // min_c never exceeds rem_beats_i, so the narrowing is lossless.
   assign beats_o = min_c[TRAN_BYTE_NUM_WIDTH-1:0];
   assign arlen_o = 8'(min_c - CW'(1));

endmodule

// File: rtl/axi4_burst_read_engine.sv
// AXI4 read master that copies a contiguous byte range into a local SRAM.
// Ports:
//  clk, rst_n                : clock, asynchronous active-low reset
//  start_i, base_addr_i,
//  total_byte_num_i          : transfer request, sampled while idle
//  busy_o, done_o, error_o   : transfer status; error_o is valid with done_o
//  sram_addr_o/data_o/valid_o,
//  sram_ready_i              : SRAM write port, one word per accepted R beat
//  m_axi_ar*                 : AR channel (INCR bursts, never crossing 4 KB)
//  m_axi_r*                  : R channel, back-pressured by sram_ready_i
module axi4_burst_read_engine
   import axi4_pkg::*;
#(
   parameter int AXI_ID_WIDTH        = 1,
   parameter int AXI_ADDR_WIDTH      = 32,
   parameter int AXI_DATA_WIDTH      = 32,
   parameter int TRAN_BYTE_NUM_WIDTH = 16,
   parameter int SRAM_ADDR_WIDTH     = 32,
   parameter int MAX_BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING     = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_i,
   input  logic [AXI_ADDR_WIDTH-1:0]      base_addr_i,
   input  logic [TRAN_BYTE_NUM_WIDTH-1:0] total_byte_num_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic [SRAM_ADDR_WIDTH-1:0]     sram_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]      sram_data_o,
   output logic                           sram_valid_o,
   input  logic                           sram_ready_i,
   output logic [AXI_ID_WIDTH-1:0]        m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
   output logic [7:0]                     m_axi_arlen,
   output logic [2:0]                     m_axi_arsize,
   output logic [1:0]                     m_axi_arburst,
   output logic                           m_axi_arvalid,
   input  logic                           m_axi_arready,
   input  logic [AXI_ID_WIDTH-1:0]        m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
   input  logic [1:0]                     m_axi_rresp,
   input  logic                           m_axi_rlast,
   input  logic                           m_axi_rvalid,
   output logic                           m_axi_rready
);

   localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
   localparam int AXI_SIZE   = $clog2(DATA_BYTES);
   localparam int OW         = $clog2(MAX_OUTSTANDING + 1);

   state_e                         state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic [TRAN_BYTE_NUM_WIDTH-1:0] rem_q, rem_d;
   logic [OW-1:0]                  outst_q, outst_d;
   logic [SRAM_ADDR_WIDTH-1:0]     sram_addr_q, sram_addr_d;
   logic                           err_q, err_d;

   logic [TRAN_BYTE_NUM_WIDTH-1:0] beats;
   logic                           ar_hs;
   logic                           r_hs;
   logic                           r_last_hs;
   logic                           misaligned;
   logic                           unused_rid;

   axi4_burst_splitter #(
      .TRAN_BYTE_NUM_WIDTH (TRAN_BYTE_NUM_WIDTH),
      .DATA_BYTES          (DATA_BYTES),
      .MAX_BURST_LEN       (MAX_BURST_LEN)
   ) u_splitter (
      .rem_beats_i (rem_q),
      .addr_lo_i   (addr_q[11:0]),
      .beats_o     (beats),
      .arlen_o     (m_axi_arlen)
   );

   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == DONE);
   assign error_o       = err_q;
   assign sram_addr_o   = sram_addr_q;
   assign sram_data_o   = m_axi_rdata;
   assign sram_valid_o  = m_axi_rvalid & busy_o;

   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arsize  = 3'(AXI_SIZE);
   assign m_axi_arburst = AXI_BURST_INCR;
   // Outstanding can only fall while ADDR is waiting, so once raised arvalid stays up until accepted.
   assign m_axi_arvalid = (state_q == ADDR) && (outst_q < OW'(MAX_OUTSTANDING));
   assign m_axi_rready  = sram_ready_i & busy_o;

   assign ar_hs      = m_axi_arvalid & m_axi_arready;
   assign r_hs       = m_axi_rvalid & m_axi_rready;
   assign r_last_hs  = r_hs & m_axi_rlast;
   assign misaligned = (|base_addr_i[AXI_SIZE-1:0]) | (|total_byte_num_i[AXI_SIZE-1:0]);
   assign unused_rid = ^m_axi_rid;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      err_d       = err_q;
      sram_addr_d = sram_addr_q;
      // Accept and completion in the same cycle cancel out.
      outst_d     = outst_q + OW'(ar_hs) - OW'(r_last_hs);

      if (r_hs) begin
         sram_addr_d = sram_addr_q + SRAM_ADDR_WIDTH'(1);
         if (m_axi_rresp != AXI_RESP_OKAY) begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               sram_addr_d = '0;
               err_d       = misaligned;
               addr_d      = base_addr_i;
               rem_d       = total_byte_num_i >> AXI_SIZE;
               if (misaligned || (total_byte_num_i == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (ar_hs) begin
               addr_d = addr_q + (AXI_ADDR_WIDTH'(beats) << AXI_SIZE);
               rem_d  = rem_q - beats;
               if (rem_q == beats) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (outst_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         outst_q     <= '0;
         sram_addr_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         outst_q     <= outst_d;
         sram_addr_q <= sram_addr_d;
         err_q       <= err_d;
      end
   end

endmodule
